// File: rtl/prbs_checker_16l.sv
// Receive-side 16-lane PRBS32 checker: each lane self-seeds from its own history,
// then every bit is checked against the prediction; lock is lost on a burst of errors.
module prbs_checker_16l #(
  parameter int          N_LANE   = 16,
  parameter int          N_PRBS   = 32,
  parameter logic [31:0] EQN      = 32'h00100002,
  parameter int          ERR_W    = 32,
  parameter int          BIT_W    = 48,
  parameter int          LOCK_WIN = 64,
  parameter int          LOCK_THR = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [N_LANE-1:0] din,
  output logic              lock,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic [N_LANE-1:0] err_lane,
  output logic [7:0]        relock_cnt,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEED  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  localparam int CNT_W  = $clog2(N_LANE + 1);
  localparam int SEED_W = $clog2(N_PRBS);
  localparam int WIN_W  = $clog2(LOCK_WIN);
  localparam int WE_W   = $clog2(LOCK_THR + N_LANE + 1);

  logic [1:0]        state_q, state_d;
  logic [N_PRBS-1:0] hist_q [N_LANE];
  logic [SEED_W-1:0] seed_cnt_q, seed_cnt_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [WE_W-1:0]   win_err_q, win_err_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [N_LANE-1:0] err_lane_q, err_lane_d;
  logic [7:0]        relock_q, relock_d;

  logic [N_LANE-1:0] e;
  logic [CNT_W-1:0]  n;
  logic [ERR_W:0]    err_sum;
  logic [BIT_W:0]    bit_sum;
  logic [WE_W-1:0]   win_sum;
  logic              win_wrap;

  // Prediction and error vector; e is only acted on in CHECK.
  always_comb begin
    e = '0;
    n = '0;
    for (int i = 0; i < N_LANE; i++) begin
      e[i] = din[i] ^ (^(hist_q[i] & EQN[N_PRBS-1:0]));
      n    = n + CNT_W'(e[i]);
    end
    err_sum  = {1'b0, err_cnt_q} + (ERR_W+1)'(n);
    bit_sum  = {1'b0, bit_cnt_q} + (BIT_W+1)'(N_LANE);
    win_sum  = win_err_q + WE_W'(n);
    win_wrap = (win_cnt_q == WIN_W'(LOCK_WIN - 1));
  end

  always_comb begin
    state_d    = state_q;
    seed_cnt_d = seed_cnt_q;
    win_cnt_d  = win_cnt_q;
    win_err_d  = win_err_q;
    err_cnt_d  = err_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    err_lane_d = err_lane_q;
    relock_d   = relock_q;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_SEED;
          seed_cnt_d = '0;
          win_cnt_d  = '0;
          win_err_d  = '0;
        end
        ST_SEED: begin
          win_cnt_d = '0;
          win_err_d = '0;
          if (seed_cnt_q == SEED_W'(N_PRBS - 1)) state_d = ST_CHECK;
          else seed_cnt_d = seed_cnt_q + 1'b1;
        end
        ST_CHECK: begin
          err_cnt_d  = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
          bit_cnt_d  = bit_sum[BIT_W] ? '1 : bit_sum[BIT_W-1:0];
          err_lane_d = err_lane_q | e;
          if (win_sum > WE_W'(LOCK_THR)) begin
            state_d    = ST_SEED;
            seed_cnt_d = '0;
            win_cnt_d  = '0;
            win_err_d  = '0;
            relock_d   = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
          end else begin
            win_cnt_d = win_wrap ? '0 : win_cnt_q + 1'b1;
            win_err_d = win_wrap ? WE_W'(n) : win_sum;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Clear discards this cycle's updates but leaves the FSM and window alone.
    if (clr) begin
      err_cnt_d  = '0;
      bit_cnt_d  = '0;
      err_lane_d = '0;
      relock_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      for (int i = 0; i < N_LANE; i++) hist_q[i] <= '0;
      seed_cnt_q <= '0;
      win_cnt_q  <= '0;
      win_err_q  <= '0;
      err_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      err_lane_q <= '0;
      relock_q   <= '0;
    end else begin
      state_q    <= state_d;
      if (en) begin
        for (int i = 0; i < N_LANE; i++) hist_q[i] <= {hist_q[i][N_PRBS-2:0], din[i]};
      end
      seed_cnt_q <= seed_cnt_d;
      win_cnt_q  <= win_cnt_d;
      win_err_q  <= win_err_d;
      err_cnt_q  <= err_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      err_lane_q <= err_lane_d;
      relock_q   <= relock_d;
    end
  end

  assign lock       = (state_q == ST_CHECK);
  assign err_cnt    = err_cnt_q;
  assign bit_cnt    = bit_cnt_q;
  assign err_lane   = err_lane_q;
  assign relock_cnt = relock_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_prbs_checker_16l.sv
// Bench for prbs_checker_16l: a table of clean/flip/enable/clear phases with
// hand-computed totals, then hand-written sequences for the multi-cycle corners.
module tb_prbs_checker_16l;

  localparam logic [31:0] EQN = 32'h00100002;

  logic        clk = 1'b0;
  logic        rst_n, en, clr;
  logic [15:0] din;
  logic        lock;
  logic [31:0] err_cnt;
  logic [47:0] bit_cnt;
  logic [15:0] err_lane;
  logic [7:0]  relock_cnt;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [31:0] gen_s [16];

  typedef struct {
    logic        en;
    logic        clr;
    logic [15:0] mask;
    int          n;
    logic        exp_lock;
    logic [31:0] exp_err;
    logic [47:0] exp_bit;
    logic [15:0] exp_lane;
    logic [7:0]  exp_relock;
  } vec_t;

  vec_t tbl [9];

  prbs_checker_16l dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr        (clr),
    .din        (din),
    .lock       (lock),
    .err_cnt    (err_cnt),
    .bit_cnt    (bit_cnt),
    .err_lane   (err_lane),
    .relock_cnt (relock_cnt),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transmit-side reference: one PRBS32 generator per lane.
  task automatic next_clean(output logic [15:0] w);
    logic b;
    for (int i = 0; i < 16; i++) begin
      b         = ^(gen_s[i] & EQN);
      gen_s[i]  = {gen_s[i][30:0], b};
      w[i]      = b;
    end
  endtask

  // Called at a negedge; returns at the next negedge, after the word was sampled.
  task automatic word_raw(input logic e, input logic c, input logic [15:0] d);
    en  = e;
    clr = c;
    din = d;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic word(input logic e, input logic c, input logic [15:0] mask);
    logic [15:0] w;
    w = '0;
    if (e) next_clean(w);
    word_raw(e, c, w ^ mask);
  endtask

  task automatic clean(input int cnt);
    for (int k = 0; k < cnt; k++) word(1'b1, 1'b0, 16'h0);
  endtask

  task automatic chk_all(input string tag, input logic l, input logic [31:0] er,
                         input logic [47:0] bi, input logic [15:0] la, input logic [7:0] rl);
    chk({tag, ".lock"}, 64'(lock), 64'(l));
    chk({tag, ".err_cnt"}, 64'(err_cnt), 64'(er));
    chk({tag, ".bit_cnt"}, 64'(bit_cnt), 64'(bi));
    chk({tag, ".err_lane"}, 64'(err_lane), 64'(la));
    chk({tag, ".relock_cnt"}, 64'(relock_cnt), 64'(rl));
  endtask

  initial begin
    logic [15:0] c1, c2, c;
    int          n1, n2, seed_left;
    logic        loss1;
    logic [31:0] exp_err;
    logic [47:0] exp_bit;
    logic [15:0] exp_lane;

    // en, clr, mask(first word), words, lock, err, bits, lanes, relock
    tbl[0] = '{1'b1, 1'b0, 16'h0000,   32, 1'b0, 32'd0, 48'd0,     16'h0000, 8'd0};
    tbl[1] = '{1'b1, 1'b0, 16'h0000,    1, 1'b1, 32'd0, 48'd0,     16'h0000, 8'd0};
    tbl[2] = '{1'b1, 1'b0, 16'h0000, 1000, 1'b1, 32'd0, 48'd16000, 16'h0000, 8'd0};
    tbl[3] = '{1'b1, 1'b0, 16'h0020,   30, 1'b1, 32'd3, 48'd16480, 16'h0020, 8'd0};
    tbl[4] = '{1'b0, 1'b0, 16'h0000,    3, 1'b0, 32'd3, 48'd16480, 16'h0020, 8'd0};
    tbl[5] = '{1'b1, 1'b0, 16'h0000,   32, 1'b0, 32'd3, 48'd16480, 16'h0020, 8'd0};
    tbl[6] = '{1'b1, 1'b0, 16'h0000,    1, 1'b1, 32'd3, 48'd16480, 16'h0020, 8'd0};
    tbl[7] = '{1'b1, 1'b1, 16'h0000,    1, 1'b1, 32'd0, 48'd0,     16'h0000, 8'd0};
    tbl[8] = '{1'b1, 1'b0, 16'h0000,   10, 1'b1, 32'd0, 48'd160,   16'h0000, 8'd0};

    for (int i = 0; i < 16; i++) gen_s[i] = 32'hACE1_0000 + 32'(i * 7919 + 1);

    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    din   = '0;
    repeat (2) @(negedge clk);
    chk_all("reset", 1'b0, 32'd0, 48'd0, 16'h0, 8'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      for (int k = 0; k < tbl[v].n; k++)
        word(tbl[v].en, tbl[v].clr && (k == 0), (k == 0) ? tbl[v].mask : 16'h0);
      chk_all($sformatf("vec%0d", v), tbl[v].exp_lock, tbl[v].exp_err,
              tbl[v].exp_bit, tbl[v].exp_lane, tbl[v].exp_relock);
    end

    // Two constant A5A5 words; while locked, predictions equal the clean stream.
    next_clean(c1);
    n1 = $countones(16'hA5A5 ^ c1);
    word_raw(1'b1, 1'b0, 16'hA5A5);
    next_clean(c2);
    n2 = $countones(16'hA5A5 ^ c2);
    word_raw(1'b1, 1'b0, 16'hA5A5);
    loss1    = (n1 > 8);
    exp_err  = loss1 ? 32'(n1) : 32'(n1 + n2);
    exp_bit  = loss1 ? 48'd176 : 48'd192;
    exp_lane = (16'hA5A5 ^ c1) | (loss1 ? 16'h0 : (16'hA5A5 ^ c2));
    chk_all("garbage", 1'b0, exp_err, exp_bit, exp_lane, 8'd1);
    seed_left = loss1 ? 31 : 32;
    clean(seed_left - 1);
    chk("relock_pre.lock", 64'(lock), 64'd0);
    clean(1);
    chk("relock.lock", 64'(lock), 64'd1);
    clean(30);
    chk("relock_run.err_cnt", 64'(err_cnt), 64'(exp_err));
    chk("relock_run.bit_cnt", 64'(bit_cnt), 64'(exp_bit + 48'd480));

    // Build err_cnt=7: lanes 0,1 flipped, lane 0 flipped again two words later.
    word(1'b1, 1'b1, 16'h0);
    chk_all("clr0", 1'b1, 32'd0, 48'd0, 16'h0, 8'd0);
    word(1'b1, 1'b0, 16'h0003);
    word(1'b1, 1'b0, 16'h0000);
    word(1'b1, 1'b0, 16'h0001);
    clean(30);
    chk_all("err7", 1'b1, 32'd7, 48'd528, 16'h0003, 8'd0);
    clean(70);
    word(1'b1, 1'b1, 16'h0004);
    chk_all("clr_err", 1'b1, 32'd0, 48'd0, 16'h0, 8'd0);
    clean(25);
    chk_all("after_clr", 1'b1, 32'd2, 48'd400, 16'h0004, 8'd0);

    // Loss of lock in the same cycle as clr.
    next_clean(c);
    word_raw(1'b1, 1'b1, ~c);
    chk_all("loss_clr", 1'b0, 32'd0, 48'd0, 16'h0, 8'd0);
    clean(31);
    chk("loss_clr_seed.lock", 64'(lock), 64'd0);
    clean(1);
    chk("loss_clr_relock.lock", 64'(lock), 64'd1);
    clean(40);
    chk("loss_clr_run.err_cnt", 64'(err_cnt), 64'd0);
    chk("loss_clr_run.bit_cnt", 64'(bit_cnt), 64'd640);

    // Saturation from a preloaded near-full error count.
    force dut.err_cnt_d = 32'hFFFF_FFFE;
    word(1'b1, 1'b0, 16'h0);
    release dut.err_cnt_d;
    chk("preload.err_cnt", 64'(err_cnt), 64'h0000_0000_FFFF_FFFE);
    word(1'b1, 1'b0, 16'h000F);
    chk("sat.err_cnt", 64'(err_cnt), 64'h0000_0000_FFFF_FFFF);
    clean(2);
    chk("sat_hold1.err_cnt", 64'(err_cnt), 64'h0000_0000_FFFF_FFFF);
    clean(30);
    chk("sat_hold2.err_cnt", 64'(err_cnt), 64'h0000_0000_FFFF_FFFF);
    chk("sat.err_lane", 64'(err_lane), 64'h000F);

    // Asynchronous reset between edges while checking.
    clean(100);
    chk("pre_rst.lock", 64'(lock), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 1'b0, 32'd0, 48'd0, 16'h0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clean(32);
    chk("post_rst_seed.lock", 64'(lock), 64'd0);
    clean(1);
    chk("post_rst.lock", 64'(lock), 64'd1);
    clean(5);
    chk("post_rst.err_cnt", 64'(err_cnt), 64'd0);
    chk("post_rst.bit_cnt", 64'(bit_cnt), 64'd80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
